// File: rtl/stack_seq_pkg.sv
// Shared types and constants for the register-pair stack sequencer.
package stack_seq_pkg;

    localparam int unsigned SP_W   = 16;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [IDX_W-1:0] SP_LO_IDX = 3'd6;
    localparam logic [IDX_W-1:0] SP_HI_IDX = 3'd7;
    localparam logic [1:0]       PAIR_RSVD = 2'd3;

    typedef enum logic {
        OP_PUSH = 1'b0,
        OP_POP  = 1'b1
    } op_t;

    typedef enum logic [3:0] {
        IDLE,
        P_RDH,
        P_WRH,
        P_RDL,
        P_WRL,
        Q_RDL,
        Q_WRL,
        Q_RDH,
        Q_WRH,
        SPW_L,
        SPW_H,
        DONE
    } state_t;

endpackage

// File: rtl/stack_sequencer.sv
// PUSH/POP of a register pair through byte-wide memory, with SP writeback to the bank.
// Outputs are registered from the next-state values so each state presents its own requests.
module stack_sequencer
    import stack_seq_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [1:0]        pairSel,
    input  logic [SP_W-1:0]   rbSp,
    input  logic [DATA_W-1:0] rbDataIn,
    output logic [IDX_W-1:0]  rbRegNum,
    output logic [DATA_W-1:0] rbDataOut,
    output logic              rbWriteEnable,
    output logic [SP_W-1:0]   memAddr,
    output logic [DATA_W-1:0] memWData,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] memRData,
    input  logic              memReady,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t              state_q, state_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [IDX_W-1:0]    hi_idx_q, hi_idx_d;
    logic [IDX_W-1:0]    lo_idx_d;

    logic [IDX_W-1:0]    reg_num_d;
    logic [DATA_W-1:0]   data_out_d;
    logic                we_d;
    logic [SP_W-1:0]     addr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                wr_d;
    logic                rd_d;
    logic                busy_d;
    logic                done_d;
    logic                err_d;

    // State register, datapath and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            sp_q          <= '0;
            data_q        <= '0;
            hi_idx_q      <= '0;
            rbRegNum      <= '0;
            rbDataOut     <= '0;
            rbWriteEnable <= 1'b0;
            memAddr       <= '0;
            memWData      <= '0;
            memWrite      <= 1'b0;
            memRead       <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state_q       <= state_d;
            sp_q          <= sp_d;
            data_q        <= data_d;
            hi_idx_q      <= hi_idx_d;
            rbRegNum      <= reg_num_d;
            rbDataOut     <= data_out_d;
            rbWriteEnable <= we_d;
            memAddr       <= addr_d;
            memWData      <= wdata_d;
            memWrite      <= wr_d;
            memRead       <= rd_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
        end
    end

    // Next-state/datapath, then output decode of the state being entered
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        data_d     = data_q;
        hi_idx_d   = hi_idx_q;
        err_d      = 1'b0;
        reg_num_d  = '0;
        data_out_d = '0;
        we_d       = 1'b0;
        addr_d     = '0;
        wdata_d    = '0;
        wr_d       = 1'b0;
        rd_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (pairSel == PAIR_RSVD) begin
                        err_d = 1'b1;
                    end else begin
                        hi_idx_d = {pairSel, 1'b0};
                        if (op_t'(op) == OP_POP) begin
                            sp_d    = rbSp;
                            state_d = Q_RDL;
                        end else begin
                            sp_d    = rbSp - SP_W'(1);
                            state_d = P_RDH;
                        end
                    end
                end
            end
            P_RDH: begin
                data_d  = rbDataIn;
                state_d = P_WRH;
            end
            P_WRH: if (memReady) begin
                sp_d    = sp_q - SP_W'(1);
                state_d = P_RDL;
            end
            P_RDL: begin
                data_d  = rbDataIn;
                state_d = P_WRL;
            end
            P_WRL: if (memReady) state_d = SPW_L;
            Q_RDL: if (memReady) begin
                data_d  = memRData;
                sp_d    = sp_q + SP_W'(1);
                state_d = Q_WRL;
            end
            Q_WRL: state_d = Q_RDH;
            Q_RDH: if (memReady) begin
                data_d  = memRData;
                sp_d    = sp_q + SP_W'(1);
                state_d = Q_WRH;
            end
            Q_WRH: state_d = SPW_L;
            SPW_L: state_d = SPW_H;
            SPW_H: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        lo_idx_d = {hi_idx_d[IDX_W-1:1], 1'b1};

        unique case (state_d)
            P_RDH: reg_num_d = hi_idx_d;
            P_RDL: reg_num_d = lo_idx_d;
            P_WRH, P_WRL: begin
                wr_d    = 1'b1;
                addr_d  = sp_d;
                wdata_d = data_d;
            end
            Q_RDL, Q_RDH: begin
                rd_d   = 1'b1;
                addr_d = sp_d;
            end
            Q_WRL: begin
                we_d       = 1'b1;
                reg_num_d  = lo_idx_d;
                data_out_d = data_d;
            end
            Q_WRH: begin
                we_d       = 1'b1;
                reg_num_d  = hi_idx_d;
                data_out_d = data_d;
            end
            SPW_L: begin
                we_d       = 1'b1;
                reg_num_d  = SP_LO_IDX;
                data_out_d = sp_d[7:0];
            end
            SPW_H: begin
                we_d       = 1'b1;
                reg_num_d  = SP_HI_IDX;
                data_out_d = sp_d[15:8];
            end
            default: ;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Bench for stack_sequencer: register bank and memory models, an expected-access
// scoreboard built from the PUSH/POP rules, and literal pins on the directed cases.
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        op = 1'b0;
    logic [1:0]  pairSel = 2'd0;
    logic        memReady = 1'b0;
    logic [15:0] rbSp;
    logic [7:0]  rbDataIn;
    logic [2:0]  rbRegNum;
    logic [7:0]  rbDataOut;
    logic        rbWriteEnable;
    logic [15:0] memAddr;
    logic [7:0]  memWData;
    logic        memWrite;
    logic        memRead;
    logic [7:0]  memRData;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .pairSel(pairSel),
        .rbSp(rbSp), .rbDataIn(rbDataIn), .rbRegNum(rbRegNum), .rbDataOut(rbDataOut),
        .rbWriteEnable(rbWriteEnable), .memAddr(memAddr), .memWData(memWData),
        .memWrite(memWrite), .memRead(memRead), .memRData(memRData),
        .memReady(memReady), .busy(busy), .done(done), .err(err)
    );

    logic [7:0] regs [8];
    logic [7:0] mem  [65536];

    assign rbDataIn = regs[rbRegNum];
    assign rbSp     = {regs[7], regs[6]};
    assign memRData = mem[memAddr];

    int vec = 0;
    int fails = 0;

    logic        pk_en = 1'b0;
    logic        pk_mem = 1'b0;
    logic [15:0] pk_addr = 16'd0;
    logic [7:0]  pk_data = 8'd0;

    // Bank and memory: bench pokes plus DUT-driven writes
    always @(posedge clk) begin
        if (pk_en) begin
            if (pk_mem) mem[pk_addr] = pk_data;
            else        regs[pk_addr[2:0]] = pk_data;
        end
        if (memWrite && memReady) mem[memAddr] = memWData;
        if (rbWriteEnable)        regs[rbRegNum] = rbDataOut;
    end

    // Memory handshake: wcfg wait cycles before memReady on each request
    int wcfg = 0;
    int wcnt = 0;
    always @(posedge clk) begin
        #2;
        if (memReady || !(memWrite || memRead)) wcnt = 0;
        memReady = 1'b0;
        if (memWrite || memRead) begin
            if (wcnt >= wcfg) memReady = 1'b1;
            else              wcnt++;
        end
    end

    typedef struct {
        int          kind;   // 0 mem write, 1 mem read, 2 bank write
        logic [15:0] addr;
        logic [7:0]  data;
    } ev_t;

    ev_t expq[$];
    int  rd_idx = 0;
    int  skip_to = 0;
    bit  exp_busy = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic push_ev(input int kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        expq.push_back(e);
    endtask

    task automatic check_ev(input int kind, input logic [15:0] addr, input logic [7:0] data);
        ev_t e;
        vec++;
        if (rd_idx >= expq.size()) begin
            fails++;
            $display("FAIL unexpected_access: kind %0d addr %0h data %0h, expected none", kind, addr, data);
        end else begin
            e = expq[rd_idx];
            rd_idx++;
            chk("access_kind", 32'(kind), 32'(e.kind));
            chk("access_addr", 32'(addr), 32'(e.addr));
            if (kind != 1) chk("access_data", 32'(data), 32'(e.data));
        end
    endtask

    logic        prev_wait = 1'b0;
    logic [15:0] prev_addr = 16'd0;
    logic [7:0]  prev_wdata = 8'd0;

    // Per-cycle compare against the scoreboard and the invariants
    always @(negedge clk) begin
        if (rd_idx < skip_to) rd_idx = skip_to;
        if (reset) begin
            chk("strobe_exclusive", 32'($countones({memWrite, memRead, rbWriteEnable}) <= 1), 32'd1);
            chk("busy", 32'(busy), 32'(exp_busy));
            if (!exp_busy)
                chk("idle_outputs", 32'({memWrite, memRead, rbWriteEnable, done, rbRegNum,
                                         |memAddr, |memWData, |rbDataOut}), 32'd0);
            if (prev_wait && (memWrite || memRead)) begin
                chk("hold_addr", 32'(memAddr), 32'(prev_addr));
                chk("hold_wdata", 32'(memWData), 32'(prev_wdata));
            end
            if (memWrite && memReady) check_ev(0, memAddr, memWData);
            if (memRead && memReady)  check_ev(1, memAddr, 8'h00);
            if (rbWriteEnable)        check_ev(2, {13'd0, rbRegNum}, rbDataOut);
        end
        prev_wait  = (memWrite || memRead) && !memReady;
        prev_addr  = memAddr;
        prev_wdata = memWData;
    end

    task automatic poke(input bit is_mem, input logic [15:0] addr, input logic [7:0] data);
        pk_en = 1'b1; pk_mem = is_mem; pk_addr = addr; pk_data = data;
        @(posedge clk); #2;
        pk_en = 1'b0;
    endtask

    task automatic set_sp(input logic [15:0] v);
        poke(1'b0, 16'd6, v[7:0]);
        poke(1'b0, 16'd7, v[15:8]);
    endtask

    // Expected accesses: PUSH stores high then low below SP; POP loads low then high upward
    task automatic queue_op(input logic o, input logic [1:0] p, output logic [15:0] fin);
        logic [15:0] s;
        logic [15:0] s1;
        logic [2:0]  hi;
        logic [2:0]  lo;
        s  = rbSp;
        s1 = s + 16'd1;
        hi = {p, 1'b0};
        lo = {p, 1'b1};
        if (!o) begin
            push_ev(0, s - 16'd1, regs[hi]);
            push_ev(0, s - 16'd2, regs[lo]);
            fin = s - 16'd2;
        end else begin
            push_ev(1, s, 8'h00);
            push_ev(2, {13'd0, lo}, mem[s]);
            push_ev(1, s1, 8'h00);
            push_ev(2, {13'd0, hi}, mem[s1]);
            fin = s + 16'd2;
        end
        push_ev(2, 16'd6, fin[7:0]);
        push_ev(2, 16'd7, fin[15:8]);
    endtask

    task automatic run_op(input logic o, input logic [1:0] p, input int w, input bit mess,
                          output int lat);
        logic [15:0] fin;
        int n;
        wcfg = w;
        queue_op(o, p, fin);
        op = o; pairSel = p; start = 1'b1;
        @(posedge clk); #2;
        exp_busy = 1'b1;
        if (mess) begin
            op = ~o;
            pairSel = 2'd3;
        end else begin
            start = 1'b0;
        end
        n = 0;
        while (n < 200) begin
            if (n == 3) start = 1'b0;
            @(posedge clk); #2;
            n++;
            if (done) break;
        end
        start = 1'b0; op = 1'b0; pairSel = 2'd0;
        // the accept edge closes cycle k; done is high in the cycle closed by edge k+n+1
        lat = n + 1;
        chk("latency", 32'(lat), 32'(7 + 2 * w));
        @(posedge clk); #2;
        chk("done_pulse_width", 32'(done), 32'd0);
        exp_busy = 1'b0;
        chk("final_sp", 32'(rbSp), 32'(fin));
        chk("events_consumed", 32'(rd_idx), 32'(expq.size()));
    endtask

    int          lat;
    bit          found;
    logic [15:0] fin_r;

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_strobes", 32'({memWrite, memRead, rbWriteEnable}), 32'd0);
        chk("rst_addr", 32'(memAddr), 32'd0);
        chk("rst_regnum", 32'(rbRegNum), 32'd0);
        reset = 1'b1;
        @(posedge clk); #2;

        // PUSH BC at SP=FFFE
        set_sp(16'hFFFE); poke(1'b0, 16'd0, 8'h12); poke(1'b0, 16'd1, 8'h34);
        run_op(1'b0, 2'd0, 0, 1'b0, lat);
        chk("t1_lat", 32'(lat), 32'd7);
        chk("t1_mem_fffd", 32'(mem[16'hFFFD]), 32'h12);
        chk("t1_mem_fffc", 32'(mem[16'hFFFC]), 32'h34);
        chk("t1_sp", 32'(rbSp), 32'hFFFC);

        // POP DE
        run_op(1'b1, 2'd1, 0, 1'b0, lat);
        chk("t2_lat", 32'(lat), 32'd7);
        chk("t2_d", 32'(regs[2]), 32'h12);
        chk("t2_e", 32'(regs[3]), 32'h34);
        chk("t2_sp", 32'(rbSp), 32'hFFFE);

        // PUSH HL with SP wrapping below zero
        set_sp(16'h0000); poke(1'b0, 16'd4, 8'hAB); poke(1'b0, 16'd5, 8'hCD);
        run_op(1'b0, 2'd2, 0, 1'b0, lat);
        chk("t3_mem_ffff", 32'(mem[16'hFFFF]), 32'hAB);
        chk("t3_mem_fffe", 32'(mem[16'hFFFE]), 32'hCD);
        chk("t3_sp", 32'(rbSp), 32'hFFFE);

        // POP BC with SP wrapping past FFFF
        set_sp(16'hFFFF); poke(1'b1, 16'hFFFF, 8'h5A); poke(1'b1, 16'h0000, 8'hA5);
        run_op(1'b1, 2'd0, 0, 1'b0, lat);
        chk("t4_c", 32'(regs[1]), 32'h5A);
        chk("t4_b", 32'(regs[0]), 32'hA5);
        chk("t4_sp", 32'(rbSp), 32'h0001);

        // PUSH DE with three wait cycles per write
        set_sp(16'h8000); poke(1'b0, 16'd2, 8'h77); poke(1'b0, 16'd3, 8'h88);
        run_op(1'b0, 2'd1, 3, 1'b0, lat);
        chk("t5_lat", 32'(lat), 32'd13);
        chk("t5_mem_7fff", 32'(mem[16'h7FFF]), 32'h77);
        chk("t5_mem_7ffe", 32'(mem[16'h7FFE]), 32'h88);

        // POP HL with waits, start held and op/pairSel changed after acceptance
        run_op(1'b1, 2'd2, 2, 1'b1, lat);
        chk("t6_lat", 32'(lat), 32'd11);
        chk("t6_h", 32'(regs[4]), 32'h77);
        chk("t6_l", 32'(regs[5]), 32'h88);
        chk("t6_sp", 32'(rbSp), 32'h8000);

        // PUSH BC with one wait, inputs disturbed while busy
        run_op(1'b0, 2'd0, 1, 1'b1, lat);
        chk("t7_lat", 32'(lat), 32'd9);
        chk("t7_mem_7fff", 32'(mem[16'h7FFF]), 32'hA5);
        chk("t7_mem_7ffe", 32'(mem[16'h7FFE]), 32'h5A);

        // Reserved pair: error pulse, nothing else
        op = 1'b0; pairSel = 2'd3; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; pairSel = 2'd0;
        chk("t8_err_pulse", 32'(err), 32'd1);
        chk("t8_busy", 32'(busy), 32'd0);
        @(posedge clk); #2;
        chk("t8_err_clear", 32'(err), 32'd0);
        chk("t8_sp", 32'(rbSp), 32'h7FFE);

        // Reset while the low byte is being written
        set_sp(16'h2000); poke(1'b0, 16'd0, 8'h3C); poke(1'b0, 16'd1, 8'hC3);
        poke(1'b1, 16'h1FFE, 8'hEE);
        wcfg = 3;
        queue_op(1'b0, 2'd0, fin_r);
        op = 1'b0; pairSel = 2'd0; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        exp_busy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(posedge clk); #2;
            if (memWrite && memAddr == 16'h1FFE) found = 1'b1;
        end
        chk("t9_reach_low_write", 32'(found), 32'd1);
        reset = 1'b0;
        @(posedge clk); #2;
        exp_busy = 1'b0;
        skip_to = expq.size();
        chk("t9_busy", 32'(busy), 32'd0);
        chk("t9_memwrite", 32'(memWrite), 32'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk("t9_sp", 32'(rbSp), 32'h2000);
        chk("t9_mem_1fff", 32'(mem[16'h1FFF]), 32'h3C);
        chk("t9_mem_1ffe", 32'(mem[16'h1FFE]), 32'hEE);

        // Clean operation after the abort
        run_op(1'b0, 2'd0, 0, 1'b0, lat);
        chk("t10_mem_1ffe", 32'(mem[16'h1FFE]), 32'hC3);
        chk("t10_sp", 32'(rbSp), 32'h1FFE);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule
